// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the RAM bus arbiter: FSM state encodings,
// counter widths and a small index helper used by the requester picker.
package mem_bus_arbiter_pkg;

   // Width of the locked-burst counter (holds up to MAX_LOCK-1 = 14).
   localparam int LOCK_CNT_W = 4;

   // Width of the WAIT-state down counter (holds up to MEM_LAT-2 = 5).
   localparam int WAIT_CNT_W = 3;

   // Arbiter FSM encodings.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_e;

   // Wrap an index that may have run one lap past n back into 0..n-1.
   function automatic int wrapIdx(input int idx, input int n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational winner selection: requester 0 wins outright when CPU priority
// is enabled, otherwise the first active request at or after the round-robin
// pointer wins, wrapping around the top.
module rr_picker
   import mem_bus_arbiter_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   input  logic             cpu_prio_i,
   output logic [N_REQ-1:0] pick_o,
   output logic [IDX_W-1:0] pick_idx_o
);

   logic             found;
   logic [IDX_W-1:0] candIdx;

   // Scan requesters starting at the pointer; the first hit becomes the pick.
   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      found      = 1'b0;
      candIdx    = '0;
      if (cpu_prio_i && req_i[0]) begin
         pick_o[0] = 1'b1;
         found     = 1'b1;
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            candIdx = IDX_W'(wrapIdx(int'(rr_ptr_i) + k, N_REQ));
            if (!found && req_i[candIdx]) begin
               found           = 1'b1;
               pick_o[candIdx] = 1'b1;
               pick_idx_o      = candIdx;
            end
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM bus arbiter. Picks one requester, latches its access,
// runs one fixed-latency RAM cycle and pulses ack with read data. A locked
// owner may keep the bus for back-to-back accesses, bounded while others wait.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int MEM_LAT  = 1,
   parameter int CPU_PRIO = 1,
   parameter int MAX_LOCK = 4
) (
   input  logic               clk,
   input  logic               reset_cycle,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   lock,
   input  logic [8*N_REQ-1:0] addr_in,
   input  logic [N_REQ-1:0]   we_in,
   input  logic [8*N_REQ-1:0] wdata_in,
   output logic [N_REQ-1:0]   grant,
   output logic [N_REQ-1:0]   ack,
   output logic [7:0]         rdata,
   output logic [7:0]         mem_addr,
   output logic               mem_we,
   output logic [7:0]         mem_wdata,
   input  logic [7:0]         mem_rdata,
   output logic               busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_e             state_q,    state_d;
   logic [N_REQ-1:0]       grant_q,    grant_d;
   logic [IDX_W-1:0]       winner_q,   winner_d;
   logic [IDX_W-1:0]       rr_ptr_q,   rr_ptr_d;
   logic [LOCK_CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]             addr_q,     addr_d;
   logic [7:0]             wdata_q,    wdata_d;
   logic                   we_q,       we_d;
   logic [7:0]             rdata_q,    rdata_d;

   logic [N_REQ-1:0]       pick;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       sel_idx;
   logic                   hold_bus;
   logic                   others_req;
   logic [7:0]             addr_arr  [N_REQ];
   logic [7:0]             wdata_arr [N_REQ];

   // Split the packed per-requester buses into indexable arrays.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = addr_in[8*g +: 8];
      assign wdata_arr[g] = wdata_in[8*g +: 8];
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i      (req),
      .rr_ptr_i   (rr_ptr_q),
      .cpu_prio_i (CPU_PRIO != 0),
      .pick_o     (pick),
      .pick_idx_o (pick_idx)
   );

   // State and datapath registers; reset drops the bus at once, no ack.
   always_ff @(posedge clk or posedge reset_cycle) begin
      if (reset_cycle) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         winner_q   <= '0;
         rr_ptr_q   <= '0;
         lock_cnt_q <= '0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         winner_q   <= winner_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         rdata_q    <= rdata_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, sequence the access, and in DONE
   // either continue a locked burst or release the bus and advance rr_ptr.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      winner_d   = winner_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      wait_cnt_d = wait_cnt_q;
      rdata_d    = rdata_q;
      hold_bus   = lock[winner_q] && req[winner_q];
      others_req = |(req & ~grant_q);
      sel_idx    = (state_q == ARB_IDLE) ? pick_idx : winner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;

      case (state_q)
         ARB_IDLE: begin
            if (|req) begin
               state_d  = ARB_ACCESS;
               grant_d  = pick;
               winner_d = pick_idx;
               addr_d   = addr_arr[sel_idx];
               wdata_d  = wdata_arr[sel_idx];
               we_d     = we_in[sel_idx];
            end
         end
         ARB_ACCESS: begin
            if (MEM_LAT > 1) begin
               state_d    = ARB_WAIT;
               wait_cnt_d = WAIT_CNT_W'(MEM_LAT - 2);
            end else begin
               state_d = ARB_DONE;
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
            end
         end
         ARB_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = ARB_DONE;
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
            end
         end
         ARB_DONE: begin
            if (hold_bus && (!others_req ||
                             lock_cnt_q < LOCK_CNT_W'(MAX_LOCK - 1))) begin
               state_d = ARB_ACCESS;
               addr_d  = addr_arr[sel_idx];
               wdata_d = wdata_arr[sel_idx];
               we_d    = we_in[sel_idx];
               if (others_req) begin
                  lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
               end
            end else begin
               state_d    = ARB_IDLE;
               grant_d    = '0;
               lock_cnt_d = '0;
               rr_ptr_d   = (winner_q == IDX_W'(N_REQ - 1)) ? '0
                                                             : winner_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant     = grant_q;
   assign ack       = (state_q == ARB_DONE) ? grant_q : '0;
   assign busy      = (state_q != ARB_IDLE);
   assign mem_we    = (state_q == ARB_ACCESS) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single 8-bit RAM bus between up to N_REQ requesters: CPU control path (index 0), loader/DMA, debug port.
- Latches the winner's address, write-enable and write data, then sequences one RAM access of fixed latency.
- Returns read data with a one-cycle ack pulse.
- Supports locked back-to-back bursts, with a bounded length.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- MEM_LAT, 1, cycles from mem_addr valid to mem_rdata valid (1..7).
- CPU_PRIO, 1, when 1, requester 0 wins whenever it requests; otherwise round-robin.
- MAX_LOCK, 4, maximum consecutive grants to one locked requester while others wait (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset_cycle  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester access request (level).
- lock  in  N_REQ  per-requester "keep bus after this access".
- addr_in  in  8*N_REQ  packed addresses; requester i at [8i+7:8i].
- we_in  in  N_REQ  1 = write.
- wdata_in  in  8*N_REQ  packed write data.
- grant  out  N_REQ  one-hot current owner; 0 when idle.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- rdata  out  8  read data; valid while ack is high, held afterwards.
- mem_addr  out  8  RAM address.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0; lock_cnt=0; all outputs 0.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick a winner. With CPU_PRIO=1 and req[0] set, the winner is 0. Otherwise the winner is the first set req found searching from rr_ptr upward, with wrap-around.
  - At that edge: register grant, latch addr/we/wdata of the winner, go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr/mem_wdata come from the latches (registered, stable until DONE).
  - mem_we=1 for exactly this cycle if the latched we=1.
  - Next state: WAIT if MEM_LAT>1, else DONE.
- WAIT: count MEM_LAT-1 cycles, then go to DONE.
- Read capture: mem_rdata is sampled into rdata at the edge leaving the last ACCESS/WAIT cycle. For writes, rdata is unchanged.
- DONE (1 cycle):
  - ack[winner]=1.
  - If lock[winner] and req[winner] are both sampled high, the other requesters do not all have req=0, and lock_cnt<MAX_LOCK-1: latch new inputs from the same winner, increment lock_cnt, go to ACCESS. Grant stays high.
  - If lock[winner] and req[winner] are high and all other req are 0: continue the same way, but do not increment lock_cnt (no one is starved).
  - Otherwise: grant=0, lock_cnt=0, rr_ptr=(winner+1) mod N_REQ, go to IDLE.
- Latency: with req sampled at edge t, ack is high during cycle t+1+MEM_LAT (MEM_LAT=1 gives 2 cycles). IDLE→ACCESS never occurs in the same cycle as DONE, so each transaction costs MEM_LAT+2 cycles; locked bursts cost MEM_LAT+1.
- Inputs are latched, so dropping req before ack still completes the transaction and still pulses ack. A requester holding req after ack is a new request.
- rr_ptr is updated only on release; CPU_PRIO wins do not reset it.
- Requests arriving during a transaction are ignored until IDLE, except for the locked owner.
- Reset mid-transaction: bus released immediately, mem_we drops asynchronously, no ack is issued.
- Invariants: grant is one-hot or zero; ack is a subset of grant; mem_we is never high outside ACCESS.

Decomposition:
- Add ARB_IDLE/ARB_ACCESS/ARB_WAIT/ARB_DONE state encodings (2-bit) to the shared parameters include, next to the existing STATE_* constants.
- One combinational sub-module, rr_picker: inputs req, rr_ptr, cpu_prio; outputs one-hot pick and its index. It is unit-tested separately.

Test Plan:
- Single read: MEM_LAT=1; RAM[0x20]=0x5A; req[1]=1, addr 0x20, we=0 → grant=3'b010 next cycle; ack[1] 2 cycles after req; rdata=0x5A; busy back to 0.
- Single write: req[0], addr 0x10, wdata 0xC3, we=1 → mem_we high exactly 1 cycle with mem_addr=0x10, mem_wdata=0xC3; RAM[0x10]=0xC3.
- Priority vs round-robin: req=3'b111 held.
  - CPU_PRIO=1: grants 0,0,0…
  - CPU_PRIO=0: grant order 0,1,2,0 with rr_ptr wrap.
- Locked burst: MAX_LOCK=4; requester 1 holds lock+req while req[2] is high → 4 back-to-back acks to 1 (each MEM_LAT+1 apart), then release, then requester 2 granted.
- Uncontended lock: only requester 1 requests with lock=1 → more than 4 consecutive acks without release.
- Reset mid-WAIT: MEM_LAT=3; assert reset_cycle during WAIT → grant, mem_we and busy go to 0 immediately; no ack; next request is served normally from rr_ptr=0.
